npcg_toggle_mnc_dispatcher: RTL and testbench
=============================================

Name: npcg_toggle_mnc_dispatcher

Overview:
- Sits between the NPCG command front-end and the pool of Toggle MNC sub-command modules (readID, readStatus, setFeature, reset, ...), all of which share one primitive-manager (PM) port.
- Decodes each upstream command by target ID and opcode, and forwards it to exactly one slot.
- Grants that slot exclusive ownership of the PM bus and the read-data return path until the slot signals its last step.
- Adds a watchdog counter that flags a stuck owner.

Parameters:
- NumberOfWays, 4, width of way-select and PM target-way buses.
- NumberOfSlots, 4, number of attached sub-command modules.
- SlotTargetIDs, {5'd5,5'd5,5'd5,5'd5}, packed 5*NumberOfSlots, target ID that selects slot i (slot i at bits [5i+4:5i]).
- SlotOpcodes, {6'b101100,6'b101101,6'b101010,6'b101011}, packed 6*NumberOfSlots, opcode that selects slot i; slot 0 is readID (6'b101011).
- TimeoutCycles, 16'd65535, BUSY cycles before oTimeout sets.

Ports:
- iSystemClock  in  1  clock
- iReset  in  1  synchronous active-high reset
- iOpcode  in  6  upstream opcode
- iTargetID  in  5  upstream target ID
- iCMDValid  in  1  upstream command valid
- oCMDReady  out  1  upstream command ready
- oSlotCMDValid  out  NumberOfSlots  per-slot command valid (one-hot or zero)
- iSlotCMDReady  in  NumberOfSlots  per-slot oCMDReady
- iSlotLastStep  in  NumberOfSlots  per-slot oLastStep
- iSlotPCommand  in  8*NumberOfSlots  per-slot PM command
- iSlotPCommandOption  in  3*NumberOfSlots  per-slot PM option
- iSlotTargetWay  in  NumberOfWays*NumberOfSlots  per-slot target way
- iSlotNumOfData  in  16*NumberOfSlots  per-slot PM length
- iSlotCASelect  in  NumberOfSlots  per-slot C/A select
- iSlotCAData  in  8*NumberOfSlots  per-slot C/A byte
- oSlotPM_Ready  out  8*NumberOfSlots  iPM_Ready gated to owner
- oSlotPM_LastStep  out  8*NumberOfSlots  iPM_LastStep gated to owner
- iSlotReadData  in  32*NumberOfSlots; iSlotReadLast, iSlotReadValid  in  NumberOfSlots  per-slot read stream
- oSlotReadReady  out  NumberOfSlots  iReadReady gated to owner
- oReadData  out  32; oReadLast, oReadValid  out  1  muxed read stream
- iReadReady  in  1  upstream read ready
- iPM_Ready, iPM_LastStep  in  8  from PM
- oPM_PCommand  out  8; oPM_PCommandOption  out  3; oPM_TargetWay  out  NumberOfWays; oPM_NumOfData  out  16; oPM_CASelect  out  1; oPM_CAData  out  8  muxed to PM
- oBusy  out  1  BUSY state
- oOwner  out  clog2(NumberOfSlots)  current owner index
- oDecodeError  out  1  one-cycle pulse
- oTimeout  out  1  sticky watchdog flag

Behaviour:
- Decode (combinational): wMatch[i] = (iTargetID==SlotTargetIDs[i]) && (iOpcode==SlotOpcodes[i]). Lowest matching index wins; wHit = |wMatch.
- States:
  - IDLE=2'b00
  - BUSY=2'b01
  - DRAIN=2'b11, waiting for owner's iSlotCMDReady to return high
- IDLE:
  - oCMDReady = wHit ? iSlotCMDReady[sel] : 1.
  - oSlotCMDValid[sel] = iCMDValid && wHit; all other bits are 0.
  - Accept = iCMDValid && oCMDReady.
  - Accept with hit: rOwner<=sel, counter<=0, oTimeout<=0, next state BUSY.
  - Accept without hit: command is dropped, oDecodeError=1 for that cycle, state stays IDLE.
- BUSY:
  - oCMDReady=0; oSlotCMDValid=0.
  - PM outputs = owner slot's fields.
  - iPM_Ready/iPM_LastStep are routed to the owner only; other slots see 0.
  - Read stream is muxed from the owner. oSlotReadReady[owner]=iReadReady; all others 0.
  - Counter increments and saturates at TimeoutCycles. On reaching it, oTimeout<=1 and stays set. The state does not change on timeout.
  - iSlotLastStep[owner] goes to DRAIN.
- DRAIN: PM outputs still muxed from the owner; go to IDLE when iSlotCMDReady[owner]==1.
- IDLE PM outputs are all 0. The sub-module registers its trigger on the accept edge, so its first PM command appears in BUSY cycle 1; there is no lost cycle.
- Other slots' LastStep or ReadValid while not owner: ignored, never forwarded.
- Reset (any state): state IDLE, rOwner 0, counter 0, oTimeout 0. All outputs 0 except oCMDReady, which follows the IDLE rule.
- Latency: command accept to PM visibility 0 cycles after the state register updates. Owner LastStep to next accept takes at least 2 cycles.

Decomposition:
- Shared package npcg_toggle_pkg holds:
  - state encodings
  - PM command one-hot constants (Timer=8'b0000_0001, DI=8'b0000_0010, CAL=8'b0000_1000, PBR=8'b0100_0000)
  - readID target/opcode constants
- One sub-module, npcg_toggle_slot_decoder: parameter table to priority-encoded sel and wHit.

Test Plan:
- readID command (target 5, opcode 6'b101011), slot0 ready -> oSlotCMDValid=4'b0001 for 1 cycle, oBusy next cycle, oPM_PCommand equals slot0's 8'b0100_0000, other slots' PM_Ready read 0.
- Command target 5, opcode 6'b000000 -> accepted in 1 cycle, oDecodeError pulse, stays IDLE, no slot valid.
- Slot1 owning; slot2 drives ReadValid=1, data 32'hDEADBEEF -> oReadValid stays 0; slot1 data 32'h12345678 with iReadReady=1 -> passes through, oSlotReadReady=4'b0010.
- Owner asserts LastStep while its CMDReady stays 0 for 3 cycles -> DRAIN for 3 cycles, oCMDReady=0, then IDLE.
- TimeoutCycles=16 with owner never finishing -> oTimeout=1 at BUSY cycle 16 and stays set; a new accept clears it.
- iReset asserted mid-BUSY -> next cycle IDLE, PM outputs 0, oTimeout 0, oOwner 0.

Source files
------------

// File: rtl/npcg_toggle_pkg.sv
// Shared types and constants for the NPCG Toggle MNC command path:
// dispatcher FSM encodings, PM one-hot commands and readID decode values.
package npcg_toggle_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_BUSY  = 2'b01,
        S_DRAIN = 2'b11
    } state_t;

    localparam logic [7:0] PM_TIMER = 8'b0000_0001;
    localparam logic [7:0] PM_DI    = 8'b0000_0010;
    localparam logic [7:0] PM_CAL   = 8'b0000_1000;
    localparam logic [7:0] PM_PBR   = 8'b0100_0000;

    localparam logic [4:0] READID_TARGET = 5'd5;
    localparam logic [5:0] READID_OPCODE = 6'b101011;

endpackage

// File: rtl/npcg_toggle_slot_decoder.sv
// Matches target ID / opcode against the per-slot table;
// the lowest matching slot index wins.
module npcg_toggle_slot_decoder
    import npcg_toggle_pkg::*;
#(
    parameter int NumberOfSlots = 4,
    parameter int SelW = (NumberOfSlots > 1) ? $clog2(NumberOfSlots) : 1,
    parameter logic [5*NumberOfSlots-1:0] SlotTargetIDs = {4{READID_TARGET}},
    parameter logic [6*NumberOfSlots-1:0] SlotOpcodes =
        {6'b101100, 6'b101101, 6'b101010, READID_OPCODE}
) (
    input  logic [4:0]      iTargetID,
    input  logic [5:0]      iOpcode,
    output logic [SelW-1:0] oSel,
    output logic            oHit
);

    always_comb begin
        oSel = '0;
        oHit = 1'b0;
        // Walk downward so the lowest match is the one left standing.
        for (int i = NumberOfSlots - 1; i >= 0; i--) begin
            if (iTargetID == SlotTargetIDs[5*i +: 5] &&
                iOpcode == SlotOpcodes[6*i +: 6]) begin
                oSel = SelW'(i);
                oHit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/npcg_toggle_mnc_dispatcher.sv
// Routes NPCG commands to one Toggle MNC slot and gives that slot
// exclusive use of the shared PM port and read path until it finishes.
module npcg_toggle_mnc_dispatcher
    import npcg_toggle_pkg::*;
#(
    parameter int NumberOfWays = 4,
    parameter int NumberOfSlots = 4,
    parameter logic [5*NumberOfSlots-1:0] SlotTargetIDs = {4{READID_TARGET}},
    parameter logic [6*NumberOfSlots-1:0] SlotOpcodes =
        {6'b101100, 6'b101101, 6'b101010, READID_OPCODE},
    parameter logic [15:0] TimeoutCycles = 16'd65535,
    localparam int SelW = (NumberOfSlots > 1) ? $clog2(NumberOfSlots) : 1
) (
    input  logic                              iSystemClock,
    input  logic                              iReset,
    input  logic [5:0]                        iOpcode,
    input  logic [4:0]                        iTargetID,
    input  logic                              iCMDValid,
    output logic                              oCMDReady,
    output logic [NumberOfSlots-1:0]          oSlotCMDValid,
    input  logic [NumberOfSlots-1:0]          iSlotCMDReady,
    input  logic [NumberOfSlots-1:0]          iSlotLastStep,
    input  logic [8*NumberOfSlots-1:0]        iSlotPCommand,
    input  logic [3*NumberOfSlots-1:0]        iSlotPCommandOption,
    input  logic [NumberOfWays*NumberOfSlots-1:0] iSlotTargetWay,
    input  logic [16*NumberOfSlots-1:0]       iSlotNumOfData,
    input  logic [NumberOfSlots-1:0]          iSlotCASelect,
    input  logic [8*NumberOfSlots-1:0]        iSlotCAData,
    output logic [8*NumberOfSlots-1:0]        oSlotPM_Ready,
    output logic [8*NumberOfSlots-1:0]        oSlotPM_LastStep,
    input  logic [32*NumberOfSlots-1:0]       iSlotReadData,
    input  logic [NumberOfSlots-1:0]          iSlotReadLast,
    input  logic [NumberOfSlots-1:0]          iSlotReadValid,
    output logic [NumberOfSlots-1:0]          oSlotReadReady,
    output logic [31:0]                       oReadData,
    output logic                              oReadLast,
    output logic                              oReadValid,
    input  logic                              iReadReady,
    input  logic [7:0]                        iPM_Ready,
    input  logic [7:0]                        iPM_LastStep,
    output logic [7:0]                        oPM_PCommand,
    output logic [2:0]                        oPM_PCommandOption,
    output logic [NumberOfWays-1:0]           oPM_TargetWay,
    output logic [15:0]                       oPM_NumOfData,
    output logic                              oPM_CASelect,
    output logic [7:0]                        oPM_CAData,
    output logic                              oBusy,
    output logic [SelW-1:0]                   oOwner,
    output logic                              oDecodeError,
    output logic                              oTimeout
);

    state_t          state_q, state_d;
    logic [SelW-1:0] owner_q, owner_d;
    logic [15:0]     count_q, count_d;
    logic            timeout_q, timeout_d;

    logic [SelW-1:0] sel;
    logic            hit;
    logic            sel_ready;
    logic            own_ready;
    logic            own_last;
    logic            owned;

    npcg_toggle_slot_decoder #(
        .NumberOfSlots(NumberOfSlots),
        .SelW(SelW),
        .SlotTargetIDs(SlotTargetIDs),
        .SlotOpcodes(SlotOpcodes)
    ) u_dec (
        .iTargetID(iTargetID),
        .iOpcode(iOpcode),
        .oSel(sel),
        .oHit(hit)
    );

    assign owned = (state_q != S_IDLE);

    // Owner mux for PM fields, PM handshakes and the read stream.
    always_comb begin
        own_ready          = 1'b0;
        own_last           = 1'b0;
        sel_ready          = 1'b0;
        oPM_PCommand       = '0;
        oPM_PCommandOption = '0;
        oPM_TargetWay      = '0;
        oPM_NumOfData      = '0;
        oPM_CASelect       = 1'b0;
        oPM_CAData         = '0;
        oSlotPM_Ready      = '0;
        oSlotPM_LastStep   = '0;
        oSlotReadReady     = '0;
        oReadData          = '0;
        oReadLast          = 1'b0;
        oReadValid         = 1'b0;
        for (int i = 0; i < NumberOfSlots; i++) begin
            if (sel == SelW'(i)) begin
                sel_ready = iSlotCMDReady[i];
            end
            if (owner_q == SelW'(i)) begin
                own_ready = iSlotCMDReady[i];
                own_last  = iSlotLastStep[i];
                if (owned) begin
                    oPM_PCommand       = iSlotPCommand[8*i +: 8];
                    oPM_PCommandOption = iSlotPCommandOption[3*i +: 3];
                    oPM_TargetWay      = iSlotTargetWay[NumberOfWays*i +: NumberOfWays];
                    oPM_NumOfData      = iSlotNumOfData[16*i +: 16];
                    oPM_CASelect       = iSlotCASelect[i];
                    oPM_CAData         = iSlotCAData[8*i +: 8];
                    oSlotPM_Ready[8*i +: 8]    = iPM_Ready;
                    oSlotPM_LastStep[8*i +: 8] = iPM_LastStep;
                    oSlotReadReady[i]  = iReadReady;
                    oReadData          = iSlotReadData[32*i +: 32];
                    oReadLast          = iSlotReadLast[i];
                    oReadValid         = iSlotReadValid[i];
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        count_d       = count_q;
        timeout_d     = timeout_q;
        oCMDReady     = 1'b0;
        oSlotCMDValid = '0;
        oDecodeError  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                oCMDReady = hit ? sel_ready : 1'b1;
                if (iCMDValid && hit) begin
                    oSlotCMDValid[sel] = 1'b1;
                end
                if (iCMDValid && oCMDReady) begin
                    if (hit) begin
                        owner_d   = sel;
                        count_d   = '0;
                        timeout_d = 1'b0;
                        state_d   = S_BUSY;
                    end else begin
                        oDecodeError = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (count_q != TimeoutCycles) begin
                    count_d = count_q + 16'd1;
                end
                if (count_d == TimeoutCycles) begin
                    timeout_d = 1'b1;
                end
                if (own_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (own_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
        end
    end

    assign oBusy    = (state_q == S_BUSY);
    assign oOwner   = owner_q;
    assign oTimeout = timeout_q;

endmodule

// File: tb/tb_npcg_toggle_mnc_dispatcher.sv
// Directed bench for the Toggle MNC dispatcher: decode, ownership,
// read muxing, drain handshake, watchdog and reset.
module tb_npcg_toggle_mnc_dispatcher;

    logic        clk = 1'b0;
    logic        iReset;
    logic [5:0]  iOpcode;
    logic [4:0]  iTargetID;
    logic        iCMDValid;
    logic        oCMDReady;
    logic [3:0]  oSlotCMDValid;
    logic [3:0]  iSlotCMDReady;
    logic [3:0]  iSlotLastStep;
    logic [31:0] iSlotPCommand;
    logic [11:0] iSlotPCommandOption;
    logic [15:0] iSlotTargetWay;
    logic [63:0] iSlotNumOfData;
    logic [3:0]  iSlotCASelect;
    logic [31:0] iSlotCAData;
    logic [31:0] oSlotPM_Ready;
    logic [31:0] oSlotPM_LastStep;
    logic [127:0] iSlotReadData;
    logic [3:0]  iSlotReadLast;
    logic [3:0]  iSlotReadValid;
    logic [3:0]  oSlotReadReady;
    logic [31:0] oReadData;
    logic        oReadLast;
    logic        oReadValid;
    logic        iReadReady;
    logic [7:0]  iPM_Ready;
    logic [7:0]  iPM_LastStep;
    logic [7:0]  oPM_PCommand;
    logic [2:0]  oPM_PCommandOption;
    logic [3:0]  oPM_TargetWay;
    logic [15:0] oPM_NumOfData;
    logic        oPM_CASelect;
    logic [7:0]  oPM_CAData;
    logic        oBusy;
    logic [1:0]  oOwner;
    logic        oDecodeError;
    logic        oTimeout;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    npcg_toggle_mnc_dispatcher #(
        .NumberOfWays(4),
        .NumberOfSlots(4),
        .SlotTargetIDs({5'd5, 5'd5, 5'd5, 5'd5}),
        .SlotOpcodes({6'b101100, 6'b101101, 6'b101010, 6'b101011}),
        .TimeoutCycles(16'd16)
    ) dut (
        .iSystemClock(clk),
        .iReset(iReset),
        .iOpcode(iOpcode),
        .iTargetID(iTargetID),
        .iCMDValid(iCMDValid),
        .oCMDReady(oCMDReady),
        .oSlotCMDValid(oSlotCMDValid),
        .iSlotCMDReady(iSlotCMDReady),
        .iSlotLastStep(iSlotLastStep),
        .iSlotPCommand(iSlotPCommand),
        .iSlotPCommandOption(iSlotPCommandOption),
        .iSlotTargetWay(iSlotTargetWay),
        .iSlotNumOfData(iSlotNumOfData),
        .iSlotCASelect(iSlotCASelect),
        .iSlotCAData(iSlotCAData),
        .oSlotPM_Ready(oSlotPM_Ready),
        .oSlotPM_LastStep(oSlotPM_LastStep),
        .iSlotReadData(iSlotReadData),
        .iSlotReadLast(iSlotReadLast),
        .iSlotReadValid(iSlotReadValid),
        .oSlotReadReady(oSlotReadReady),
        .oReadData(oReadData),
        .oReadLast(oReadLast),
        .oReadValid(oReadValid),
        .iReadReady(iReadReady),
        .iPM_Ready(iPM_Ready),
        .iPM_LastStep(iPM_LastStep),
        .oPM_PCommand(oPM_PCommand),
        .oPM_PCommandOption(oPM_PCommandOption),
        .oPM_TargetWay(oPM_TargetWay),
        .oPM_NumOfData(oPM_NumOfData),
        .oPM_CASelect(oPM_CASelect),
        .oPM_CAData(oPM_CAData),
        .oBusy(oBusy),
        .oOwner(oOwner),
        .oDecodeError(oDecodeError),
        .oTimeout(oTimeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [5:0] op);
        iTargetID = 5'd5;
        iOpcode   = op;
        iCMDValid = 1'b1;
        tick();
        iCMDValid = 1'b0;
        iOpcode   = 6'd0;
    endtask

    task automatic finish_owner(input int idx);
        iSlotLastStep[idx] = 1'b1;
        tick();
        iSlotLastStep = '0;
        tick();
    endtask

    task automatic test_reset();
        iReset = 1'b1;
        tick();
        tick();
        iReset = 1'b0;
        #1;
        ntests++;
        if (oBusy !== 1'b0) begin
            nfail++;
            $display("FAIL reset_busy: got %b expected 0", oBusy);
        end
        ntests++;
        if ({oOwner, oTimeout, oPM_PCommand, oSlotCMDValid} !== 15'd0) begin
            nfail++;
            $display("FAIL reset_outs: got %h expected 0",
                     {oOwner, oTimeout, oPM_PCommand, oSlotCMDValid});
        end
        ntests++;
        if (oCMDReady !== 1'b1) begin
            nfail++;
            $display("FAIL reset_ready: got %b expected 1", oCMDReady);
        end
    endtask

    task automatic test_readid();
        iTargetID = 5'd5;
        iOpcode   = 6'b101011;
        iCMDValid = 1'b1;
        #1;
        ntests++;
        if (oSlotCMDValid !== 4'b0001 || oCMDReady !== 1'b1) begin
            nfail++;
            $display("FAIL readid_valid: got %b/%b expected 0001/1",
                     oSlotCMDValid, oCMDReady);
        end
        tick();
        iCMDValid = 1'b0;
        iOpcode   = 6'd0;
        iPM_Ready = 8'hFF;
        #1;
        ntests++;
        if (oBusy !== 1'b1 || oOwner !== 2'd0 || oSlotCMDValid !== 4'b0000) begin
            nfail++;
            $display("FAIL readid_busy: got %b/%0d/%b expected 1/0/0000",
                     oBusy, oOwner, oSlotCMDValid);
        end
        ntests++;
        if (oPM_PCommand !== 8'b0100_0000 || oPM_CAData !== 8'hA0 ||
            oPM_NumOfData !== 16'h0100) begin
            nfail++;
            $display("FAIL readid_pm: got %h/%h/%h expected 40/a0/0100",
                     oPM_PCommand, oPM_CAData, oPM_NumOfData);
        end
        ntests++;
        if (oSlotPM_Ready !== 32'h0000_00FF) begin
            nfail++;
            $display("FAIL readid_pmready: got %h expected 000000ff",
                     oSlotPM_Ready);
        end
        iPM_Ready = 8'h00;
        finish_owner(0);
        ntests++;
        if (oBusy !== 1'b0 || oPM_PCommand !== 8'h00) begin
            nfail++;
            $display("FAIL readid_done: got %b/%h expected 0/00",
                     oBusy, oPM_PCommand);
        end
    endtask

    task automatic test_decode_error();
        iTargetID = 5'd5;
        iOpcode   = 6'b000000;
        iCMDValid = 1'b1;
        #1;
        ntests++;
        if (oDecodeError !== 1'b1 || oCMDReady !== 1'b1 ||
            oSlotCMDValid !== 4'b0000) begin
            nfail++;
            $display("FAIL decerr_pulse: got %b/%b/%b expected 1/1/0000",
                     oDecodeError, oCMDReady, oSlotCMDValid);
        end
        tick();
        iCMDValid = 1'b0;
        #1;
        ntests++;
        if (oBusy !== 1'b0 || oDecodeError !== 1'b0) begin
            nfail++;
            $display("FAIL decerr_idle: got %b/%b expected 0/0",
                     oBusy, oDecodeError);
        end
    endtask

    task automatic test_read_mux();
        accept(6'b101010);
        iReadReady     = 1'b1;
        iSlotReadValid = 4'b0100;
        iSlotReadData  = {32'h0, 32'hDEADBEEF, 32'h12345678, 32'h0};
        iSlotReadLast  = 4'b0110;
        #1;
        ntests++;
        if (oReadValid !== 1'b0 || oSlotReadReady !== 4'b0010) begin
            nfail++;
            $display("FAIL read_other: got %b/%b expected 0/0010",
                     oReadValid, oSlotReadReady);
        end
        iSlotReadValid = 4'b0110;
        #1;
        ntests++;
        if (oReadValid !== 1'b1 || oReadData !== 32'h12345678 ||
            oReadLast !== 1'b1) begin
            nfail++;
            $display("FAIL read_owner: got %b/%h/%b expected 1/12345678/1",
                     oReadValid, oReadData, oReadLast);
        end
        ntests++;
        if (oPM_PCommand !== 8'h08 || oPM_TargetWay !== 4'b0010 ||
            oPM_PCommandOption !== 3'd2 || oPM_CASelect !== 1'b1) begin
            nfail++;
            $display("FAIL read_pm: got %h/%b/%0d/%b expected 08/0010/2/1",
                     oPM_PCommand, oPM_TargetWay, oPM_PCommandOption, oPM_CASelect);
        end
        iSlotReadValid = '0;
        iSlotReadLast  = '0;
        iReadReady     = 1'b0;
        iSlotLastStep  = 4'b1000;
        tick();
        iSlotLastStep  = '0;
        ntests++;
        if (oBusy !== 1'b1 || oOwner !== 2'd1) begin
            nfail++;
            $display("FAIL read_foreign_last: got %b/%0d expected 1/1",
                     oBusy, oOwner);
        end
        finish_owner(1);
    endtask

    task automatic test_drain();
        accept(6'b101101);
        iSlotCMDReady = 4'b1011;
        iSlotLastStep = 4'b0100;
        tick();
        iSlotLastStep = '0;
        for (int i = 0; i < 3; i++) begin
            ntests++;
            if (oBusy !== 1'b0 || oCMDReady !== 1'b0 || oPM_PCommand !== 8'h02) begin
                nfail++;
                $display("FAIL drain_%0d: got %b/%b/%h expected 0/0/02",
                         i, oBusy, oCMDReady, oPM_PCommand);
            end
            tick();
        end
        iSlotCMDReady = 4'b1111;
        #1;
        ntests++;
        if (oCMDReady !== 1'b0) begin
            nfail++;
            $display("FAIL drain_exit_ready: got %b expected 0", oCMDReady);
        end
        tick();
        ntests++;
        if (oCMDReady !== 1'b1 || oPM_PCommand !== 8'h00 || oBusy !== 1'b0) begin
            nfail++;
            $display("FAIL drain_idle: got %b/%h/%b expected 1/00/0",
                     oCMDReady, oPM_PCommand, oBusy);
        end
    endtask

    task automatic test_timeout();
        accept(6'b101100);
        for (int i = 1; i < 16; i++) tick();
        ntests++;
        if (oTimeout !== 1'b0) begin
            nfail++;
            $display("FAIL timeout_early: got %b expected 0", oTimeout);
        end
        tick();
        ntests++;
        if (oTimeout !== 1'b1) begin
            nfail++;
            $display("FAIL timeout_set: got %b expected 1", oTimeout);
        end
        for (int i = 0; i < 5; i++) tick();
        ntests++;
        if (oTimeout !== 1'b1 || oBusy !== 1'b1 || oOwner !== 2'd3) begin
            nfail++;
            $display("FAIL timeout_sticky: got %b/%b/%0d expected 1/1/3",
                     oTimeout, oBusy, oOwner);
        end
        finish_owner(3);
        ntests++;
        if (oTimeout !== 1'b1) begin
            nfail++;
            $display("FAIL timeout_idle: got %b expected 1", oTimeout);
        end
        accept(6'b101011);
        ntests++;
        if (oTimeout !== 1'b0 || oOwner !== 2'd0) begin
            nfail++;
            $display("FAIL timeout_clear: got %b/%0d expected 0/0",
                     oTimeout, oOwner);
        end
        finish_owner(0);
    endtask

    task automatic test_reset_mid_busy();
        accept(6'b101100);
        for (int i = 0; i < 20; i++) tick();
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        ntests++;
        if (oBusy !== 1'b0 || oOwner !== 2'd0 || oTimeout !== 1'b0) begin
            nfail++;
            $display("FAIL rst_busy_state: got %b/%0d/%b expected 0/0/0",
                     oBusy, oOwner, oTimeout);
        end
        ntests++;
        if (oPM_PCommand !== 8'h00 || oPM_NumOfData !== 16'h0000 ||
            oPM_TargetWay !== 4'b0000) begin
            nfail++;
            $display("FAIL rst_busy_pm: got %h/%h/%b expected 00/0000/0000",
                     oPM_PCommand, oPM_NumOfData, oPM_TargetWay);
        end
    endtask

    initial begin
        iReset              = 1'b1;
        iOpcode             = 6'd0;
        iTargetID           = 5'd0;
        iCMDValid           = 1'b0;
        iSlotCMDReady       = 4'b1111;
        iSlotLastStep       = 4'b0000;
        iSlotPCommand       = {8'h01, 8'h02, 8'h08, 8'h40};
        iSlotPCommandOption = {3'd4, 3'd3, 3'd2, 3'd1};
        iSlotTargetWay      = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
        iSlotNumOfData      = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
        iSlotCASelect       = 4'b1010;
        iSlotCAData         = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        iSlotReadData       = '0;
        iSlotReadLast       = '0;
        iSlotReadValid      = '0;
        iReadReady          = 1'b0;
        iPM_Ready           = 8'h00;
        iPM_LastStep        = 8'h00;
        test_reset();
        test_readid();
        test_decode_error();
        test_read_mux();
        test_drain();
        test_timeout();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
